// File: rtl/regfile_alu_ctrl_pkg.sv
// Shared decode constants for the RV32I register-file / ALU / control slice.
// Holds ALU op codes, immediate-format one-hots, access sizes and opcodes.
package regfile_alu_ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    typedef enum logic [5:0] {
        EXT_NONE  = 6'b000000,
        EXT_I     = 6'b000001,
        EXT_S     = 6'b000010,
        EXT_B     = 6'b000100,
        EXT_ISHAM = 6'b001000
    } ext_op_e;

    typedef enum logic [2:0] {
        DM_WORD  = 3'd0,
        DM_HALF  = 3'd1,
        DM_HALFU = 3'd2,
        DM_BYTE  = 3'd3,
        DM_BYTEU = 3'd4
    } dmem_type_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        dmem_type_e dmem_type;
        logic       wb_sel;
        alu_op_e    alu_op;
        logic       alu_src;
        ext_op_e    ext_op;
    } ctrl_t;

    // Shamt immediates are zero-extended so SRAI's funct7 bit never leaks into B.
    function automatic logic [31:0] gen_imm(input ext_op_e ext, input logic [31:0] ins);
        case (ext)
            EXT_I:     gen_imm = {{20{ins[31]}}, ins[31:20]};
            EXT_S:     gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            EXT_B:     gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            EXT_ISHAM: gen_imm = {27'd0, ins[24:20]};
            default:   gen_imm = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_alu_ctrl_alu.sv
// Combinational RV32I integer ALU: ten operations, shifts use b[4:0].
module rfac_alu
    import regfile_alu_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  alu_op_e       op_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(DW-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(DW-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/regfile_alu_ctrl.sv
// RV32I single-cycle slice: instruction decode, 32x32 register file and ALU.
// Decode and reads are combinational; only register writes are clocked.
module regfile_alu_ctrl
    import regfile_alu_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [31:0]   instr_i,
    input  logic          hold_i,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic [4:0]    dbg_addr_i,
    output logic          reg_write_o,
    output logic          mem_write_o,
    output logic [2:0]    dmem_type_o,
    output logic          wb_sel_o,
    output logic [4:0]    alu_op_o,
    output logic          alu_src_o,
    output logic [5:0]    ext_op_o,
    output logic [DW-1:0] alu_result_o,
    output logic          zero_o,
    output logic [DW-1:0] rs2_data_o,
    output logic [DW-1:0] dbg_data_o
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       f7_alt;
    ctrl_t      ctrl;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign f7_alt = instr_i[30];

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case (f3)
                    3'b000: ctrl.alu_op = f7_alt ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl.alu_op = ALU_SLL;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b101: ctrl.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_AND;
                endcase
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = EXT_I;
                case (f3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b001: begin ctrl.alu_op = ALU_SLL; ctrl.ext_op = EXT_ISHAM; end
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b101: begin
                        ctrl.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        ctrl.ext_op = EXT_ISHAM;
                    end
                    3'b110: ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.wb_sel    = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_I;
                    case (f3)
                        3'b000: ctrl.dmem_type = DM_BYTE;
                        3'b001: ctrl.dmem_type = DM_HALF;
                        3'b100: ctrl.dmem_type = DM_BYTEU;
                        3'b101: ctrl.dmem_type = DM_HALFU;
                        default: ctrl.dmem_type = DM_WORD;
                    endcase
                end
            end
            OP_STORE: begin
                if (f3 inside {3'b000, 3'b001, 3'b010}) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_S;
                    case (f3)
                        3'b000: ctrl.dmem_type = DM_BYTE;
                        3'b001: ctrl.dmem_type = DM_HALF;
                        default: ctrl.dmem_type = DM_WORD;
                    endcase
                end
            end
            OP_BRANCH: begin
                if (f3 inside {3'b000, 3'b001}) begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.ext_op = EXT_B;
                end
            end
            default: ctrl = '0;
        endcase
    end

    logic [DW-1:0] rf_q [32];
    logic [DW-1:0] rs1_data, rs2_data, imm, alu_b, rf_d;

    assign rs1_data = rf_q[rs1];
    assign rs2_data = rf_q[rs2];
    assign imm      = gen_imm(ctrl.ext_op, instr_i);
    assign alu_b    = ctrl.alu_src ? imm : rs2_data;

    rfac_alu #(.DW(DW)) u_alu (
        .a_i      (rs1_data),
        .b_i      (alu_b),
        .op_i     (ctrl.alu_op),
        .result_o (alu_result_o),
        .zero_o   (zero_o)
    );

    assign rf_d = ctrl.wb_sel ? dmem_rdata_i : alu_result_o;

    // NOTE: the whole register array is cleared on reset because software relies on zeroed registers.
    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (reg_write_o && (rd != 5'd0)) begin
            rf_q[rd] <= rf_d;
        end
    end

    assign reg_write_o = ctrl.reg_write & ~hold_i;
    assign mem_write_o = ctrl.mem_write & ~hold_i;
    assign dmem_type_o = ctrl.dmem_type;
    assign wb_sel_o    = ctrl.wb_sel;
    assign alu_op_o    = ctrl.alu_op;
    assign alu_src_o   = ctrl.alu_src;
    assign ext_op_o    = ctrl.ext_op;
    assign rs2_data_o  = rs2_data;
    assign dbg_data_o  = rf_q[dbg_addr_i];

endmodule

// File: tb/tb_regfile_alu_ctrl.sv
// Scoreboard bench for regfile_alu_ctrl: a driver pushes model expectations,
// a monitor pops and compares them against the DUT every falling edge.
module tb_regfile_alu_ctrl;

    localparam logic [4:0] A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
    localparam logic [4:0] A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;
    localparam logic [31:0] BAD_INSTR = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr, dmem_rdata;
    logic        hold;
    logic [4:0]  dbg_addr;
    logic        reg_write, mem_write, wb_sel, alu_src, zero;
    logic [2:0]  dmem_type;
    logic [4:0]  alu_op;
    logic [5:0]  ext_op;
    logic [31:0] alu_result, rs2_data, dbg_data;

    regfile_alu_ctrl #(.DW(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .instr_i      (instr),
        .hold_i       (hold),
        .dmem_rdata_i (dmem_rdata),
        .dbg_addr_i   (dbg_addr),
        .reg_write_o  (reg_write),
        .mem_write_o  (mem_write),
        .dmem_type_o  (dmem_type),
        .wb_sel_o     (wb_sel),
        .alu_op_o     (alu_op),
        .alu_src_o    (alu_src),
        .ext_op_o     (ext_op),
        .alu_result_o (alu_result),
        .zero_o       (zero),
        .rs2_data_o   (rs2_data),
        .dbg_data_o   (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, wb, src, z;
        logic [2:0]  dt;
        logic [4:0]  op;
        logic [5:0]  ext;
        logic [31:0] res, rs2d, dbg;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_rf [32];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            A_ADD:  return a + b;
            A_SUB:  return a - b;
            A_SLL:  return a << sh;
            A_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            A_SLTU: return (a < b) ? 32'd1 : 32'd0;
            A_XOR:  return a ^ b;
            A_SRL:  return a >> sh;
            A_SRA:  return $unsigned($signed(a) >>> sh);
            A_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    // Reference decode: written from the instruction-set tables, not from the RTL structure.
    function automatic exp_t model(input logic [31:0] ins, input logic h, input logic [31:0] dm,
                                   input logic [4:0] dbg);
        exp_t e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a, b, simm;
        logic        alt, rw, mw;
        opc  = ins[6:0];
        f3   = ins[14:12];
        alt  = ins[30];
        a    = m_rf[ins[19:15]];
        b    = m_rf[ins[24:20]];
        simm = {{20{ins[31]}}, ins[31:20]};
        rw = 0; mw = 0;
        e.wb = 0; e.src = 0; e.dt = 0; e.op = A_ADD; e.ext = 0;
        e.rs2d = m_rf[ins[24:20]];
        e.dbg  = m_rf[dbg];
        if (opc == 7'h33) begin
            rw = 1;
            case (f3)
                0: e.op = alt ? A_SUB : A_ADD;
                1: e.op = A_SLL;
                2: e.op = A_SLT;
                3: e.op = A_SLTU;
                4: e.op = A_XOR;
                5: e.op = alt ? A_SRA : A_SRL;
                6: e.op = A_OR;
                default: e.op = A_AND;
            endcase
        end else if (opc == 7'h13) begin
            rw = 1; e.src = 1;
            if (f3 == 1 || f3 == 5) begin
                e.ext = 6'd8;
                b = 32'(ins[24:20]);
                e.op = (f3 == 1) ? A_SLL : (alt ? A_SRA : A_SRL);
            end else begin
                e.ext = 6'd1;
                b = simm;
                e.op = (f3 == 0) ? A_ADD : (f3 == 2) ? A_SLT : (f3 == 3) ? A_SLTU :
                       (f3 == 4) ? A_XOR : (f3 == 6) ? A_OR : A_AND;
            end
        end else if (opc == 7'h03 && f3 inside {0, 1, 2, 4, 5}) begin
            rw = 1; e.wb = 1; e.src = 1; e.ext = 6'd1; b = simm;
            e.dt = (f3 == 0) ? 3 : (f3 == 1) ? 1 : (f3 == 2) ? 0 : (f3 == 4) ? 4 : 2;
        end else if (opc == 7'h23 && f3 <= 2) begin
            mw = 1; e.src = 1; e.ext = 6'd2;
            b = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            e.dt = (f3 == 0) ? 3 : (f3 == 1) ? 1 : 0;
        end else if (opc == 7'h63 && f3 <= 1) begin
            e.op = A_SUB; e.ext = 6'd4;
        end
        e.res = ref_alu(e.op, a, b);
        e.z   = (e.res == 0);
        e.rw  = rw & ~h;
        e.mw  = mw & ~h;
        e.wr_en   = e.rw && (ins[11:7] != 0);
        e.wr_addr = ins[11:7];
        e.wr_data = e.wb ? dm : e.res;
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic h, input logic [31:0] dm, input logic [4:0] dbg);
        exp_t e;
        @(posedge clk);
        #1;
        instr = ins; hold = h; dmem_rdata = dm; dbg_addr = dbg;
        e = model(ins, h, dm, dbg);
        sb_q.push_back(e);
        if (e.wr_en) m_rf[e.wr_addr] = e.wr_data;
    endtask

    task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        instr = BAD_INSTR; hold = 0; dbg_addr = r;
        #2;
        check(name, dbg_data, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("reg_write",  32'(reg_write),  32'(e.rw));
                check("mem_write",  32'(mem_write),  32'(e.mw));
                check("dmem_type",  32'(dmem_type),  32'(e.dt));
                check("wb_sel",     32'(wb_sel),     32'(e.wb));
                check("alu_op",     32'(alu_op),     32'(e.op));
                check("alu_src",    32'(alu_src),    32'(e.src));
                check("ext_op",     32'(ext_op),     32'(e.ext));
                check("alu_result", alu_result,      e.res);
                check("zero",       32'(zero),       32'(e.z));
                check("rs2_data",   rs2_data,        e.rs2d);
                check("dbg_data",   dbg_data,        e.dbg);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [4:0]  rd, rs1, rs2;
        f3  = 3'($urandom_range(0, 7));
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 6))
            0: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            1: begin
                if (f3 == 1 || f3 == 5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            2: return enc_i(imm, rs1, f3, rd, 7'h03);
            3: return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 3)));
            4: return enc_b(13'($urandom), rs2, rs1, 3'($urandom_range(0, 3)));
            5: return {imm, rs1, f3, rd, 7'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin : driver
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        rstn = 1'b0; instr = BAD_INSTR; hold = 1'b0; dmem_rdata = 32'd0; dbg_addr = 5'd0;
        #3;
        check("reset_dbg_x0", dbg_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 32; i++) issue(BAD_INSTR, 1'b0, 32'd0, 5'(i));

        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 0, 0, 1);           // ADDI x1,x0,5
        issue(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13), 0, 0, 2);         // ADDI x2,x0,-3
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0, 0, 3);            // ADD x3,x1,x2
        issue(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4), 0, 0, 4);            // SUB x4,x2,x1
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), 0, 0, 5);            // SLT x5,x2,x1
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6), 0, 0, 6);            // SLTU x6,x2,x1
        issue(enc_i(12'h401, 5'd2, 3'd5, 5'd7, 7'h13), 0, 0, 7);         // SRAI x7,x2,1
        issue(enc_i(12'h001, 5'd2, 3'd5, 5'd10, 7'h13), 0, 0, 10);       // SRLI x10,x2,1
        issue(enc_s(12'd8, 5'd1, 5'd0, 3'd2), 0, 0, 1);                  // SW x1,8(x0)
        issue(enc_i(12'd3, 5'd0, 3'd4, 5'd8, 7'h03), 0, 32'hAB, 8);      // LBU x8,3(x0)
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 0, 0, 0);           // ADDI x0,x0,7
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13), 1, 0, 9);           // ADDI x9,x0,1 held
        issue(enc_b(13'd8, 5'd1, 5'd1, 3'd0), 0, 0, 1);                  // BEQ x1,x1,+8
        issue(BAD_INSTR, 0, 32'hFFFF_FFFF, 0);

        peek(5'd3,  32'd2,         "x3_add");
        peek(5'd4,  32'hFFFF_FFF8, "x4_sub");
        peek(5'd5,  32'd1,         "x5_slt");
        peek(5'd6,  32'd0,         "x6_sltu");
        peek(5'd7,  32'hFFFF_FFFE, "x7_srai");
        peek(5'd10, 32'h7FFF_FFFE, "x10_srli");
        peek(5'd8,  32'h0000_00AB, "x8_lbu");
        peek(5'd0,  32'd0,         "x0_zero");
        peek(5'd9,  32'd0,         "x9_held");

        for (int n = 0; n < 400; n++)
            issue(rand_instr(), ($urandom_range(0, 4) == 0), $urandom, 5'($urandom));

        @(negedge clk);
        #2;
        instr = BAD_INSTR;
        rstn = 1'b0;
        for (int r = 1; r < 32; r += 6) begin
            dbg_addr = 5'(r);
            #1;
            check("async_reset_clear", dbg_data, 32'd0);
        end
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        @(negedge clk);
        rstn = 1'b1;

        for (int n = 0; n < 100; n++)
            issue(rand_instr(), ($urandom_range(0, 4) == 0), $urandom, 5'($urandom));

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
